icache_dm: RTL and testbench

- Direct-mapped, blocking, read-only instruction cache.
- Sits directly upstream of the core's fetch port: it serves icache_req/icache_addr and returns icache_data/icache_valid.
- Refills whole lines from a single-word-per-beat memory read port.
- Supports whole-cache invalidation (flush) for fence.i.

---
 rtl/icache_dm_pkg.sv | 15 +
 rtl/icache_dm_array.sv | 32 +++
 rtl/icache_dm.sv | 172 +++++++++++++++++
 tb/tb_icache_dm.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding
// and default geometry.
package icache_dm_pkg;

  localparam int unsigned DefaultLines     = 64;
  localparam int unsigned DefaultLineWords = 4;

  typedef enum logic [1:0] {
    IcacheIdle    = 2'd0,
    IcacheLookup  = 2'd1,
    IcacheRefill  = 2'd2,
    IcacheRespond = 2'd3
  } icache_state_e;

endpackage

// File: rtl/icache_dm_array.sv
// Tag and data storage for the instruction cache: synchronous write,
// combinational read addressed by line index.
module icache_dm_array #(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_BITS   = 22
) (
  input  logic                          clk,
  input  logic                          data_we,
  input  logic                          tag_we,
  input  logic [$clog2(LINES)-1:0]      idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
  input  logic [31:0]                   wdata,
  input  logic [TAG_BITS-1:0]           wtag,
  output logic [TAG_BITS-1:0]           rd_tag,
  output logic [31:0]                   rd_word
);

  logic [31:0]         data_q [LINES*LINE_WORDS];
  logic [TAG_BITS-1:0] tag_q  [LINES];

  // Storage is not reset; the valid bits in the top qualify every read.
  always_ff @(posedge clk) begin
    if (data_we) data_q[{idx, wr_off}] <= wdata;
    if (tag_we)  tag_q[idx] <= wtag;
  end

  assign rd_tag  = tag_q[idx];
  assign rd_word = data_q[{idx, rd_off}];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, blocking, read-only instruction cache with whole-line refill
// and single-cycle flush of all valid bits.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int unsigned LINES      = DefaultLines,
  parameter int unsigned LINE_WORDS = DefaultLineWords
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_req,
  input  logic [31:0] icache_addr,
  output logic [31:0] icache_data,
  output logic        icache_valid,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int unsigned WordBits = $clog2(LINE_WORDS);
  localparam int unsigned IdxBits  = $clog2(LINES);
  localparam int unsigned Off      = WordBits + 2;
  localparam int unsigned TagBits  = 32 - Off - IdxBits;
  localparam logic [WordBits-1:0] LastBeat = WordBits'(LINE_WORDS - 1);

  icache_state_e        state_q, state_d;
  logic [31:2]          req_addr_q, req_addr_d;
  logic [WordBits-1:0]  beat_q, beat_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [31:0]          rsp_q, rsp_d;
  logic [31:0]          icache_data_q, icache_data_d;
  logic                 icache_valid_q, icache_valid_d;
  logic                 mem_req_q, mem_req_d;
  logic [31:0]          mem_addr_q, mem_addr_d;

  logic [IdxBits-1:0]   idx;
  logic [WordBits-1:0]  woff;
  logic [TagBits-1:0]   tag;
  logic [TagBits-1:0]   rd_tag;
  logic [31:0]          rd_word;
  logic                 hit, data_we, tag_we, clear_all;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^icache_addr[1:0];
  assign idx  = req_addr_q[Off+IdxBits-1:Off];
  assign woff = req_addr_q[Off-1:2];
  assign tag  = req_addr_q[31:Off+IdxBits];
  assign hit  = valid_q[idx] && (rd_tag == tag);

  icache_dm_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_BITS   (TagBits)
  ) u_array (
    .clk     (clk),
    .data_we (data_we),
    .tag_we  (tag_we),
    .idx     (idx),
    .wr_off  (beat_q),
    .rd_off  (woff),
    .wdata   (mem_rdata),
    .wtag    (tag),
    .rd_tag  (rd_tag),
    .rd_word (rd_word)
  );

  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    beat_d         = beat_q;
    valid_d        = valid_q;
    flush_pend_d   = flush_pend_q;
    rsp_d          = rsp_q;
    icache_data_d  = icache_data_q;
    icache_valid_d = 1'b0;
    mem_req_d      = mem_req_q;
    mem_addr_d     = mem_addr_q;
    data_we        = 1'b0;
    tag_we         = 1'b0;
    clear_all      = 1'b0;

    unique case (state_q)
      IcacheIdle: begin
        if (flush) begin
          clear_all = 1'b1;
        end else if (icache_req) begin
          req_addr_d = icache_addr[31:2];
          state_d    = IcacheLookup;
        end
      end
      IcacheLookup: begin
        if (hit) begin
          icache_data_d  = rd_word;
          icache_valid_d = 1'b1;
          clear_all      = flush | flush_pend_q;
          state_d        = IcacheIdle;
        end else begin
          beat_d     = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = {req_addr_q[31:Off], {WordBits{1'b0}}, 2'b00};
          state_d    = IcacheRefill;
        end
      end
      IcacheRefill: begin
        if (mem_rvalid) begin
          data_we = 1'b1;
          if (beat_q == woff) rsp_d = mem_rdata;
          beat_d = beat_q + WordBits'(1);
          if (beat_q == LastBeat) begin
            tag_we       = 1'b1;
            valid_d[idx] = 1'b1;
            mem_req_d    = 1'b0;
            state_d      = IcacheRespond;
          end else begin
            mem_addr_d = {req_addr_q[31:Off], beat_q + WordBits'(1), 2'b00};
          end
        end
      end
      IcacheRespond: begin
        icache_data_d  = rsp_q;
        icache_valid_d = 1'b1;
        clear_all      = flush | flush_pend_q;
        state_d        = IcacheIdle;
      end
      default: state_d = IcacheIdle;
    endcase

    // A flush seen mid-transaction waits until the return to idle, so the
    // freshly refilled line is wiped together with everything else.
    if (clear_all) begin
      valid_d      = '0;
      flush_pend_d = 1'b0;
    end else if (flush && (state_q != IcacheIdle)) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IcacheIdle;
      req_addr_q     <= '0;
      beat_q         <= '0;
      valid_q        <= '0;
      flush_pend_q   <= 1'b0;
      rsp_q          <= '0;
      icache_data_q  <= '0;
      icache_valid_q <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      beat_q         <= beat_d;
      valid_q        <= valid_d;
      flush_pend_q   <= flush_pend_d;
      rsp_q          <= rsp_d;
      icache_data_q  <= icache_data_d;
      icache_valid_q <= icache_valid_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
    end
  end

  assign icache_data  = icache_data_q;
  assign icache_valid = icache_valid_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: fetches against a scripted memory with
// hand-computed addresses, data and latencies.
module tb_icache_dm;

  logic        clk;
  logic        rst;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic [31:0] icache_data;
  logic        icache_valid;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  int tests_run = 0;
  int tests_failed = 0;

  icache_dm #(
    .LINES      (64),
    .LINE_WORDS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_data  (icache_data),
    .icache_valid (icache_valid),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One fetch: memory answers each beat after 'gap' idle cycles with data
  // dbase+beat. flush_beat >= 0 pulses flush alongside that beat;
  // flush_with_req raises flush in the same cycle the request appears.
  task automatic fetch(input string name, input logic [31:0] addr, input int gap,
                       input logic [31:0] dbase, input logic [31:0] exp_data,
                       input bit exp_miss, input int flush_beat, input bit flush_with_req);
    logic [31:0] base;
    int beat;
    int wait_cnt;
    int lat;
    int exp_lat;
    bit done;
    base     = {addr[31:4], 4'h0};
    beat     = 0;
    wait_cnt = 0;
    lat      = 0;
    done     = 1'b0;
    exp_lat  = exp_miss ? 3 + 4 * (gap + 1) : 2;
    if (flush_with_req) exp_lat++;
    icache_req  = 1'b1;
    icache_addr = addr;
    flush       = flush_with_req;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
      flush      = 1'b0;
      mem_rvalid = 1'b0;
      if (icache_valid) begin
        done = 1'b1;
      end else if (mem_req) begin
        check_eq({name, " mem_addr"}, mem_addr, base + 32'(4 * beat));
        if (wait_cnt == gap) begin
          mem_rvalid = 1'b1;
          mem_rdata  = dbase + 32'(beat);
          if (beat == flush_beat) flush = 1'b1;
          beat++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
    icache_req = 1'b0;
    check_eq({name, " completed"}, 32'(done), 32'd1);
    check_eq({name, " data"}, icache_data, exp_data);
    check_eq({name, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({name, " beats"}, 32'(beat), exp_miss ? 32'd4 : 32'd0);
    check_eq({name, " mem_req low"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    check_eq({name, " valid one cycle"}, 32'(icache_valid), 32'd0);
  endtask

  initial begin
    bit reached;
    rst         = 1'b0;
    icache_req  = 1'b0;
    icache_addr = '0;
    flush       = 1'b0;
    mem_rdata   = '0;
    mem_rvalid  = 1'b0;
    #2;
    check_eq("reset icache_valid", 32'(icache_valid), 32'd0);
    check_eq("reset icache_data", icache_data, 32'd0);
    check_eq("reset mem_req", 32'(mem_req), 32'd0);
    check_eq("reset mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    fetch("cold miss", 32'h100, 0, 32'hA0, 32'hA0, 1'b1, -1, 1'b0);
    fetch("hit", 32'h108, 0, 32'h0, 32'hA2, 1'b0, -1, 1'b0);
    fetch("conflict", 32'h500, 0, 32'hB0, 32'hB0, 1'b1, -1, 1'b0);
    fetch("evicted refetch", 32'h100, 0, 32'hA0, 32'hA0, 1'b1, -1, 1'b0);
    fetch("stalled offset", 32'h20C, 3, 32'hC0, 32'hC3, 1'b1, -1, 1'b0);
    fetch("stalled line hit", 32'h204, 0, 32'h0, 32'hC1, 1'b0, -1, 1'b0);
    fetch("flush in refill", 32'h300, 0, 32'hD0, 32'hD0, 1'b1, 2, 1'b0);
    fetch("post-flush miss", 32'h300, 0, 32'hD0, 32'hD0, 1'b1, -1, 1'b0);
    fetch("flush with req", 32'h304, 0, 32'hD0, 32'hD1, 1'b1, -1, 1'b1);
    fetch("flushed other line", 32'h100, 0, 32'hA0, 32'hA0, 1'b1, -1, 1'b0);

    // Abort a refill of 0x700 with reset once beat 1 is being presented.
    reached     = 1'b0;
    icache_req  = 1'b1;
    icache_addr = 32'h700;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (mem_req && mem_addr == 32'h704) begin
        reached = 1'b1;
      end else if (mem_req && mem_addr == 32'h700) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hEE;
      end
    end
    check_eq("abort reached beat 1", 32'(reached), 32'd1);
    #1;
    rst        = 1'b0;
    icache_req = 1'b0;
    #1;
    check_eq("abort mem_req", 32'(mem_req), 32'd0);
    check_eq("abort icache_valid", 32'(icache_valid), 32'd0);
    check_eq("abort mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fetch("after abort", 32'h700, 0, 32'hE0, 32'hE0, 1'b1, -1, 1'b0);
    fetch("after abort hit", 32'h70C, 0, 32'h0, 32'hE3, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
